// File: rtl/tx_pulse_shaper_if.sv
// Symbol-in / sample-out bundle of the transmit pulse shaper.
// The master is the symbol source; the slave is the shaper.
interface tx_pulse_shaper_if #(
  parameter int WIDTH = 18
);
  logic             sam_clk_en;
  logic             sym_clk_en;
  logic [1:0]       sym_in;
  logic [1:0]       phase;
  logic             sym_err;
  logic [WIDTH-1:0] y;

  modport master (
    output sam_clk_en,
    output sym_clk_en,
    output sym_in,
    input  phase,
    input  sym_err,
    input  y
  );

  modport slave (
    input  sam_clk_en,
    input  sym_clk_en,
    input  sym_in,
    output phase,
    output sym_err,
    output y
  );
endinterface

// File: rtl/tx_pulse_shaper.sv
// 4-ASK mapper + polyphase SRRC interpolator (x4, 101 taps), 7-tick pipe.
// Define TX_SAT_EN to saturate y instead of wrapping on overflow.
module tx_pulse_shaper #(
  parameter int WIDTH    = 18,
  parameter int LENGTH   = 101,
  parameter int UPSAMPLE = 4,
  parameter int NPH      = 26,
  parameter int ACC_W    = 23
) (
  input  logic             sys_clk,
  input  logic             reset,
  tx_pulse_shaper_if.slave bus
);

  localparam int MID = (LENGTH - 1) / 2;
  localparam int L1  = (NPH + 1) / 2;
  localparam int L2  = (L1 + 1) / 2;
  localparam int L3  = (L2 + 1) / 2;
  localparam int L4  = (L3 + 1) / 2;

  typedef logic signed [WIDTH-1:0]   smp_t;
  typedef logic signed [ACC_W-1:0]   acc_t;
  typedef logic signed [2*WIDTH-1:0] prod_t;

  smp_t       s_q  [NPH];
  smp_t       s_d  [NPH];
  acc_t       p_q  [NPH];
  acc_t       p_d  [NPH];
  acc_t       l1_q [L1];
  acc_t       l1_d [L1];
  acc_t       l2_q [L2];
  acc_t       l2_d [L2];
  acc_t       l3_q [L3];
  acc_t       l3_d [L3];
  acc_t       l4_q [L4];
  acc_t       l4_d [L4];
  acc_t       l5_q;
  acc_t       l5_d;
  logic [1:0] phase_q;
  logic [1:0] phase_d;
  logic       sym_err_q;
  logic       sym_err_d;
  smp_t       y_q;
  smp_t       y_d;

  function automatic smp_t map_sym(input logic [1:0] g);
    smp_t v;
    v = '0;
    unique case (g)
      2'b00: v = -18'sd98303;
      2'b01: v = -18'sd32768;
      2'b11: v = 18'sd32768;
      2'b10: v = 18'sd98303;
    endcase
    return v;
  endfunction

  // Only the first half is stored; the upper half folds onto it.
  function automatic smp_t coef(input int i);
    int   f;
    smp_t c;
    f = (i > MID) ? (LENGTH - 1 - i) : i;
    c = '0;
    if (i < LENGTH) begin
      case (f)
        0:  c = -18'sd37;
        1:  c = 18'sd80;
        2:  c = 18'sd135;
        3:  c = 18'sd74;
        4:  c = -18'sd67;
        5:  c = -18'sd166;
        6:  c = -18'sd123;
        7:  c = 18'sd31;
        8:  c = 18'sd172;
        9:  c = 18'sd172;
        10: c = 18'sd18;
        11: c = -18'sd153;
        12: c = -18'sd196;
        13: c = -18'sd49;
        14: c = 18'sd153;
        15: c = 18'sd227;
        16: c = 18'sd74;
        17: c = -18'sd184;
        18: c = -18'sd313;
        19: c = -18'sd160;
        20: c = 18'sd178;
        21: c = 18'sd423;
        22: c = 18'sd331;
        23: c = -18'sd74;
        24: c = -18'sd466;
        25: c = -18'sd497;
        26: c = -18'sd92;
        27: c = 18'sd417;
        28: c = 18'sd571;
        29: c = 18'sd172;
        30: c = -18'sd460;
        31: c = -18'sd699;
        32: c = -18'sd178;
        33: c = 18'sd785;
        34: c = 18'sd1301;
        35: c = 18'sd607;
        36: c = -18'sd1123;
        37: c = -18'sd2619;
        38: c = -18'sd2300;
        39: c = 18'sd368;
        40: c = 18'sd4006;
        41: c = 18'sd5773;
        42: c = 18'sd3257;
        43: c = -18'sd3374;
        44: c = -18'sd10343;
        45: c = -18'sd12189;
        46: c = -18'sd3941;
        47: c = 18'sd14594;
        48: c = 18'sd38144;
        49: c = 18'sd57861;
        50: c = 18'sd65536;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  always_comb begin : comb
    prod_t prod;
    int    j;
`ifdef TX_SAT_EN
    logic [ACC_W-WIDTH:0] hi;
    hi = '0;
`endif
    prod      = '0;
    j         = 0;
    s_d       = s_q;
    p_d       = p_q;
    l1_d      = l1_q;
    l2_d      = l2_q;
    l3_d      = l3_q;
    l4_d      = l4_q;
    l5_d      = l5_q;
    phase_d   = phase_q;
    sym_err_d = sym_err_q;
    y_d       = y_q;

    if (bus.sym_clk_en && !bus.sam_clk_en) begin
      sym_err_d = 1'b1;
    end

    if (bus.sam_clk_en) begin
      if (bus.sym_clk_en) begin
        s_d[0] = map_sym(bus.sym_in);
        for (int k = 1; k < NPH; k++) begin
          s_d[k] = s_q[k-1];
        end
        phase_d = '0;
      end else if (phase_q == 2'(UPSAMPLE - 1)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + 2'd1;
      end

      // Stage 1 reads data and phase from the same register edge.
      for (int k = 0; k < NPH; k++) begin
        prod   = prod_t'(coef(k * UPSAMPLE + int'(phase_q)))
               * prod_t'(s_q[k]);
        p_d[k] = acc_t'(prod >>> (WIDTH - 1));
      end

      for (int i = 0; i < L1; i++) begin
        j       = (2 * i + 1 < NPH) ? 2 * i + 1 : 2 * i;
        l1_d[i] = (2 * i + 1 < NPH) ? p_q[2*i] + p_q[j] : p_q[2*i];
      end
      for (int i = 0; i < L2; i++) begin
        j       = (2 * i + 1 < L1) ? 2 * i + 1 : 2 * i;
        l2_d[i] = (2 * i + 1 < L1) ? l1_q[2*i] + l1_q[j] : l1_q[2*i];
      end
      for (int i = 0; i < L3; i++) begin
        j       = (2 * i + 1 < L2) ? 2 * i + 1 : 2 * i;
        l3_d[i] = (2 * i + 1 < L2) ? l2_q[2*i] + l2_q[j] : l2_q[2*i];
      end
      for (int i = 0; i < L4; i++) begin
        j       = (2 * i + 1 < L3) ? 2 * i + 1 : 2 * i;
        l4_d[i] = (2 * i + 1 < L3) ? l3_q[2*i] + l3_q[j] : l3_q[2*i];
      end
      l5_d = l4_q[0] + l4_q[L4-1];

`ifdef TX_SAT_EN
      hi = l5_q[ACC_W-1:WIDTH-1];
      if ((&hi) || (~|hi)) begin
        y_d = smp_t'(l5_q);
      end else if (l5_q[ACC_W-1]) begin
        y_d = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        y_d = {1'b0, {(WIDTH-1){1'b1}}};
      end
`else
      y_d = smp_t'(l5_q);
`endif
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      s_q       <= '{default: '0};
      p_q       <= '{default: '0};
      l1_q      <= '{default: '0};
      l2_q      <= '{default: '0};
      l3_q      <= '{default: '0};
      l4_q      <= '{default: '0};
      l5_q      <= '0;
      phase_q   <= '0;
      sym_err_q <= 1'b0;
      y_q       <= '0;
    end else begin
      s_q       <= s_d;
      p_q       <= p_d;
      l1_q      <= l1_d;
      l2_q      <= l2_d;
      l3_q      <= l3_d;
      l4_q      <= l4_d;
      l5_q      <= l5_d;
      phase_q   <= phase_d;
      sym_err_q <= sym_err_d;
      y_q       <= y_d;
    end
  end

  assign bus.phase   = phase_q;
  assign bus.sym_err = sym_err_q;
  assign bus.y       = y_q;

endmodule

// File: tb/tb_tx_pulse_shaper.sv
// Bench for tx_pulse_shaper: convolution / queue reference model,
// fixed scenarios plus a long random symbol stream.
module tb_tx_pulse_shaper;

  localparam int W = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_pulse_shaper_if #(.WIDTH(W)) bus ();

  tx_pulse_shaper dut (
    .sys_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int half [51] = '{
    -37, 80, 135, 74, -67, -166, -123, 31, 172, 172,
    18, -153, -196, -49, 153, 227, 74, -184, -313, -160,
    178, 423, 331, -74, -466, -497, -92, 417, 571, 172,
    -460, -699, -178, 785, 1301, 607, -1123, -2619, -2300, 368,
    4006, 5773, 3257, -3374, -10343, -12189, -3941, 14594, 38144, 57861,
    65536
  };
  int h [104];

  // Reference state: newest symbol first, output latency as a FIFO.
  int m_s [$];
  int pipe [$];
  int m_ph;
  bit m_err;
  int m_y;
  int alt_lev [$];

  function automatic int lvl(input logic [1:0] g);
    case (g)
      2'b00:   return -98303;
      2'b01:   return -32768;
      2'b11:   return 32768;
      default: return 98303;
    endcase
  endfunction

  function automatic int trm(input int c, input int s);
    longint p;
    p = longint'(c) * longint'(s);
    return int'(p >>> 17);
  endfunction

  function int branch();
    int acc;
    acc = 0;
    for (int k = 0; k < 26; k++) acc += trm(h[4*k+m_ph], m_s[k]);
    return acc;
  endfunction

  function automatic logic [W-1:0] as_y(input int v);
`ifdef TX_SAT_EN
    if (v > 131071) v = 131071;
    if (v < -131072) v = -131072;
`endif
    return W'(v);
  endfunction

  // Output j ticks after the first of evenly spaced symbols alt_lev[].
  function int conv(input int j);
    int acc;
    acc = 0;
    for (int m = 0; m < alt_lev.size(); m++)
      if (4 * m <= j && j - 4 * m <= 103) acc += trm(h[j-4*m], alt_lev[m]);
    return acc;
  endfunction

  task automatic model_reset();
    m_s = {};
    pipe = {};
    repeat (26) m_s.push_back(0);
    repeat (7) pipe.push_back(0);
    m_ph  = 0;
    m_err = 1'b0;
    m_y   = 0;
  endtask

  task automatic step(input bit sam, input bit sym, input logic [1:0] g);
    @(negedge clk);
    bus.sam_clk_en = sam;
    bus.sym_clk_en = sym;
    bus.sym_in     = g;
    @(posedge clk);
    #1;
    bus.sam_clk_en = 1'b0;
    bus.sym_clk_en = 1'b0;
    bus.sym_in     = 2'b00;
    if (sym && !sam) m_err = 1'b1;
    if (sam) begin
      if (sym) begin
        m_s.push_front(lvl(g));
        void'(m_s.pop_back());
        m_ph = 0;
      end else begin
        m_ph = (m_ph + 1) % 4;
      end
      pipe.push_back(branch());
      m_y = pipe.pop_front();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.y !== '0) begin
      n_fail++;
      $display("FAIL reset_y got %0d want 0", bus.y);
    end
    n_tests++;
    if (bus.phase !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_phase got %0d want 0", bus.phase);
    end
    n_tests++;
    if (bus.sym_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err got %0b want 0", bus.sym_err);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    for (int t = 0; t < 8; t++) begin
      step(1'b1, 1'b0, 2'b00);
      n_tests++;
      if (bus.phase !== 2'((t + 1) % 4)) begin
        n_fail++;
        $display("FAIL idle_phase t=%0d got %0d want %0d",
                 t, bus.phase, (t + 1) % 4);
      end
      n_tests++;
      if (bus.y !== '0) begin
        n_fail++;
        $display("FAIL idle_y t=%0d got %0d want 0", t, bus.y);
      end
    end
    n_tests++;
    if (bus.sym_err !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_err got %0b want 0", bus.sym_err);
    end
  endtask

  task automatic test_impulse();
    logic [1:0] g;
    int         d;
    int         j;
    do_reset();
    alt_lev = {};
    alt_lev.push_back(0);
    for (int m = 1; m <= 26; m++) alt_lev.push_back(lvl((m % 2) ? 2'b01 : 2'b11));
    for (int t = 0; t < 108; t++) begin
      if (t % 4 == 0 && t / 4 <= 26) begin
        g = (t == 0) ? 2'b10 : (((t / 4) % 2) ? 2'b01 : 2'b11);
        step(1'b1, 1'b1, g);
      end else begin
        step(1'b1, 1'b0, 2'b00);
      end
      j = t - 7;
      if (j >= 0 && j <= 100) begin
        d = int'($signed(bus.y)) - conv(j);
        n_tests++;
        if (d - trm(h[j], 98303) > 1 || d - trm(h[j], 98303) < -1) begin
          n_fail++;
          $display("FAIL impulse j=%0d got %0d want %0d", j, d, trm(h[j], 98303));
        end
      end
    end
  endtask

  task automatic test_constant();
    int p;
    int e;
    do_reset();
    for (int t = 0; t < 800; t++) begin
      step(1'b1, (t % 4) == 0, 2'b00);
      if (t >= 792) begin
        p = (t - 7) % 4;
        e = 0;
        for (int k = 0; k < 26; k++) e += trm(h[4*k+p], -98303);
        n_tests++;
        if (bus.y !== as_y(e)) begin
          n_fail++;
          $display("FAIL const_y t=%0d got %0d want %0d",
                   t, $signed(bus.y), e);
        end
      end
    end
  endtask

  task automatic test_random();
    int nsym  = 0;
    int since = 0;
    int gap   = 3;
    int guard = 0;
    bit sam;
    bit sym;
    do_reset();
    while (nsym < 2000 && guard < 40000) begin
      guard++;
      sam = ($urandom_range(0, 3) != 0);
      sym = sam && (since >= gap);
      step(sam, sym, 2'($urandom_range(0, 3)));
      if (sym) begin
        since = 0;
        nsym++;
        gap = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : 3;
      end else if (sam) begin
        since++;
      end
      n_tests++;
      if (bus.y !== as_y(m_y)) begin
        n_fail++;
        $display("FAIL rand_y n=%0d got %0d want %0d", nsym, $signed(bus.y), m_y);
      end
      n_tests++;
      if (bus.phase !== 2'(m_ph)) begin
        n_fail++;
        $display("FAIL rand_phase n=%0d got %0d want %0d", nsym, bus.phase, m_ph);
      end
    end
    n_tests++;
    if (bus.sym_err !== 1'b0 || nsym != 2000) begin
      n_fail++;
      $display("FAIL rand_end err=%0b syms=%0d want err=0 syms=2000",
               bus.sym_err, nsym);
    end
  endtask

  task automatic test_sym_err();
    step(1'b0, 1'b1, 2'b10);
    n_tests++;
    if (bus.sym_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set got %0b want 1", bus.sym_err);
    end
    n_tests++;
    if (bus.phase !== 2'(m_ph) || bus.y !== as_y(m_y)) begin
      n_fail++;
      $display("FAIL err_hold phase=%0d y=%0d want phase=%0d y=%0d",
               bus.phase, $signed(bus.y), m_ph, m_y);
    end
    for (int t = 0; t < 40; t++) begin
      step(1'b1, (t % 4) == 3, 2'($urandom_range(0, 3)));
      n_tests++;
      if (bus.y !== as_y(m_y) || bus.sym_err !== m_err) begin
        n_fail++;
        $display("FAIL err_after t=%0d y=%0d err=%0b want y=%0d err=%0b",
                 t, $signed(bus.y), bus.sym_err, m_y, m_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nsym  = 0;
    int since = 0;
    bit done  = 1'b0;
    bit sam;
    bit sym;
    for (int it = 0; it < 2000 && nsym < 100; it++) begin
      if (nsym == 50 && !done) begin
        done = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.y !== '0 || bus.phase !== 2'd0 || bus.sym_err !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst y=%0d phase=%0d err=%0b want 0 0 0",
                   $signed(bus.y), bus.phase, bus.sym_err);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        since = 3;
      end
      sam = ($urandom_range(0, 4) != 0);
      sym = sam && (since >= 3);
      step(sam, sym, 2'($urandom_range(0, 3)));
      if (sym) begin
        since = 0;
        nsym++;
      end else if (sam) begin
        since++;
      end
      n_tests++;
      if (bus.y !== as_y(m_y) || bus.phase !== 2'(m_ph)) begin
        n_fail++;
        $display("FAIL midrst_run n=%0d y=%0d ph=%0d want y=%0d ph=%0d",
                 nsym, $signed(bus.y), bus.phase, m_y, m_ph);
      end
    end
  endtask

  initial begin
    bus.sam_clk_en = 1'b0;
    bus.sym_clk_en = 1'b0;
    bus.sym_in     = 2'b00;
    for (int i = 0; i < 104; i++)
      h[i] = (i <= 50) ? half[i] : ((i <= 100) ? half[100-i] : 0);
    model_reset();
    test_reset();
    test_idle();
    test_impulse();
    test_constant();
    test_random();
    test_sym_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
